// File: rtl/clip_pass_sequencer_pkg.sv
// rtl/clip_pass_sequencer_pkg.sv - shared polygon, clip-side and sequencer state types
package clip_pass_sequencer_pkg;

    localparam int MAX_VERTS = 8;
    localparam int COORD_W   = 12;
    localparam int NV_W      = 4;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
    } vertex_t;

    typedef struct packed {
        logic [NV_W-1:0]             num_verts;
        vertex_t [MAX_VERTS-1:0]     verts;
    } polygon2d_t;

    // Pass order is the numeric order of these codes; RIGHT is the last pass.
    typedef enum logic [1:0] {
        SIDE_TOP    = 2'd0,
        SIDE_BOTTOM = 2'd1,
        SIDE_LEFT   = 2'd2,
        SIDE_RIGHT  = 2'd3
    } clip_side_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUTPUT = 2'd3
    } clip_seq_state_t;

    // Fewer than three vertices cannot enclose area, so the polygon is culled.
    function automatic logic is_degenerate(input polygon2d_t p);
        return p.num_verts < NV_W'(3);
    endfunction

endpackage

// File: rtl/clip_pass_sequencer.sv
// rtl/clip_pass_sequencer.sv - runs one shared poly_clip engine over TOP, BOTTOM, LEFT, RIGHT in turn
module clip_pass_sequencer
    import clip_pass_sequencer_pkg::*;
#(
    parameter int ENG_TIMEOUT = 64,
    parameter bit SKIP_EMPTY  = 1'b1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  polygon2d_t in_poly,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       eng_start,
    output logic [1:0] eng_side,
    output polygon2d_t eng_poly_in,
    input  logic       eng_done,
    input  polygon2d_t eng_poly_out,
    output polygon2d_t out_poly,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_culled,
    output logic       out_err,
    output logic       busy
);

    localparam int                 TIMER_W    = $clog2(ENG_TIMEOUT) + 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ENG_TIMEOUT - 1);

    clip_seq_state_t     state;
    clip_side_t          side;
    logic [TIMER_W-1:0]  timer;
    polygon2d_t          work;

    // The work register is both the engine operand and the final result.
    assign eng_side    = side;
    assign eng_poly_in = work;
    assign out_poly    = work;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            side       <= SIDE_TOP;
            timer      <= '0;
            work       <= '0;
            in_ready   <= 1'b1;
            eng_start  <= 1'b0;
            out_valid  <= 1'b0;
            out_culled <= 1'b0;
            out_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        work      <= in_poly;
                        side      <= SIDE_TOP;
                        state     <= ST_LAUNCH;
                        eng_start <= 1'b1;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving on the timeout cycle still counts as success.
                    if (eng_done) begin
                        work <= eng_poly_out;
                        if (side == SIDE_RIGHT) begin
                            state      <= ST_OUTPUT;
                            out_valid  <= 1'b1;
                            out_culled <= is_degenerate(eng_poly_out);
                        end else if (SKIP_EMPTY && is_degenerate(eng_poly_out)) begin
                            state      <= ST_OUTPUT;
                            out_valid  <= 1'b1;
                            out_culled <= 1'b1;
                        end else begin
                            side      <= clip_side_t'(side + 2'd1);
                            state     <= ST_LAUNCH;
                            eng_start <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                        if (timer == TIMER_LAST) begin
                            state          <= ST_OUTPUT;
                            out_valid      <= 1'b1;
                            out_err        <= 1'b1;
                            work.num_verts <= '0;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        state      <= ST_IDLE;
                        out_valid  <= 1'b0;
                        out_culled <= 1'b0;
                        out_err    <= 1'b0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    out_valid  <= 1'b0;
                    out_culled <= 1'b0;
                    out_err    <= 1'b0;
                    in_ready   <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clip_pass_sequencer.sv
// tb/tb_clip_pass_sequencer.sv - directed bench for clip_pass_sequencer with a behavioural engine model
module tb_clip_pass_sequencer;
    import clip_pass_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst;
    polygon2d_t in_poly;
    logic       in_valid;
    logic       out_ready;
    logic       spur_done;
    polygon2d_t junk_poly;

    logic       in_ready_s   [2];
    logic       eng_start_s  [2];
    logic [1:0] eng_side_s   [2];
    polygon2d_t eng_poly_in_s[2];
    logic       eng_done_s   [2];
    polygon2d_t eng_poly_out_s[2];
    polygon2d_t out_poly_s   [2];
    logic       out_valid_s  [2];
    logic       out_culled_s [2];
    logic       out_err_s    [2];
    logic       busy_s       [2];

    logic       mdl_done[2] = '{1'b0, 1'b0};
    polygon2d_t mdl_poly[2];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clip_pass_sequencer #(.ENG_TIMEOUT(64), .SKIP_EMPTY(1'b1)) dut (
        .clk(clk), .n_rst(n_rst), .in_poly(in_poly), .in_valid(in_valid), .in_ready(in_ready_s[0]),
        .eng_start(eng_start_s[0]), .eng_side(eng_side_s[0]), .eng_poly_in(eng_poly_in_s[0]),
        .eng_done(eng_done_s[0]), .eng_poly_out(eng_poly_out_s[0]), .out_poly(out_poly_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready), .out_culled(out_culled_s[0]),
        .out_err(out_err_s[0]), .busy(busy_s[0])
    );

    clip_pass_sequencer #(.ENG_TIMEOUT(64), .SKIP_EMPTY(1'b0)) dut_ns (
        .clk(clk), .n_rst(n_rst), .in_poly(in_poly), .in_valid(in_valid), .in_ready(in_ready_s[1]),
        .eng_start(eng_start_s[1]), .eng_side(eng_side_s[1]), .eng_poly_in(eng_poly_in_s[1]),
        .eng_done(eng_done_s[1]), .eng_poly_out(eng_poly_out_s[1]), .out_poly(out_poly_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready), .out_culled(out_culled_s[1]),
        .out_err(out_err_s[1]), .busy(busy_s[1])
    );

    assign eng_done_s[0]     = mdl_done[0] | spur_done;
    assign eng_done_s[1]     = mdl_done[1] | spur_done;
    assign eng_poly_out_s[0] = spur_done ? junk_poly : mdl_poly[0];
    assign eng_poly_out_s[1] = spur_done ? junk_poly : mdl_poly[1];

    // Engine model: done L cycles after start; marks the clipped side's vertex, optionally empties it.
    int         eng_lat;
    int         cull_side;
    int         pend_cnt[2] = '{0, 0};
    polygon2d_t cap_poly[2];
    logic [1:0] cap_side[2];

    function automatic polygon2d_t engine_result(input polygon2d_t p, input logic [1:0] s, input int cs);
        polygon2d_t r;
        r = p;
        r.verts[s].x = r.verts[s].x + 12'sd1;
        if (int'(s) == cs) r.num_verts = '0;
        return r;
    endfunction

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            mdl_done[g] = 1'b0;
            if (pend_cnt[g] == 1) begin
                mdl_done[g] = 1'b1;
                mdl_poly[g] = engine_result(cap_poly[g], cap_side[g], cull_side);
            end
            if (pend_cnt[g] > 0) pend_cnt[g] = pend_cnt[g] - 1;
            if (eng_start_s[g]) begin
                pend_cnt[g] = eng_lat;
                cap_poly[g] = eng_poly_in_s[g];
                cap_side[g] = eng_side_s[g];
            end
        end
    end

    int         st_cyc0[$];
    logic [1:0] st_side0[$];
    int         st_cnt1 = 0;
    int         out_rise[2] = '{0, 0};
    logic       ov_prev[2]  = '{1'b0, 1'b0};

    always @(negedge clk) begin
        if (eng_start_s[0]) begin
            st_cyc0.push_back(cyc);
            st_side0.push_back(eng_side_s[0]);
        end
        if (eng_start_s[1]) st_cnt1 = st_cnt1 + 1;
        for (int g = 0; g < 2; g++) begin
            if (out_valid_s[g] && !ov_prev[g]) out_rise[g] = cyc;
            ov_prev[g] = out_valid_s[g];
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic polygon2d_t make_poly(input int n, input int base);
        polygon2d_t p;
        p = '0;
        p.num_verts = NV_W'(n);
        for (int i = 0; i < MAX_VERTS; i++) begin
            p.verts[i].x = COORD_W'(base + i * 16);
            p.verts[i].y = COORD_W'(base * 2 - i * 8);
        end
        return p;
    endfunction

    function automatic polygon2d_t exp_passes(input polygon2d_t p, input int k);
        polygon2d_t r;
        r = p;
        for (int i = 0; i < k; i++) r.verts[i].x = r.verts[i].x + 12'sd1;
        return r;
    endfunction

    int hs;

    task automatic send(input polygon2d_t p);
        @(posedge clk);
        #1 in_poly = p;
        in_valid = 1'b1;
        @(posedge clk);
        #1 hs = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int g, input int lim, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            if (out_valid_s[g]) seen = 1'b1;
        end
        if (!seen) check(tag, 256'(0), 256'(1));
        #1;
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    polygon2d_t pa, pb, pc;
    int b0, b1;
    bit stable;

    initial begin
        n_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; spur_done = 1'b0;
        in_poly = '0; eng_lat = 2; cull_side = -1;
        junk_poly = make_poly(7, 999);

        // Power-on reset
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 256'(in_ready_s[0]), 256'(1));
        check("rst_out_valid", 256'(out_valid_s[0]), 256'(0));
        check("rst_eng_start", 256'(eng_start_s[0]), 256'(0));
        check("rst_busy", 256'(busy_s[0]), 256'(0));

        // Reset held 3 clocks while mid-WAIT
        eng_lat = 20;
        send(make_poly(4, 100));
        repeat (5) @(posedge clk);
        #1 n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 256'(in_ready_s[0]), 256'(1));
        check("midrst_out_valid", 256'(out_valid_s[0]), 256'(0));
        check("midrst_eng_start", 256'(eng_start_s[0]), 256'(0));
        check("midrst_busy", 256'(busy_s[0]), 256'(0));
        check("midrst_work", 256'(out_poly_s[0]), 256'(0));
        repeat (30) @(negedge clk);
        check("stale_done_busy", 256'(busy_s[0]), 256'(0));
        check("stale_done_work", 256'(out_poly_s[0]), 256'(0));

        // Square, L=2, four passes
        eng_lat = 2; cull_side = -1;
        pa = make_poly(4, 40);
        b0 = st_cyc0.size();
        send(pa);
        wait_out(0, 100, "sq_timeout");
        check("sq_starts", 256'(st_cyc0.size() - b0), 256'(4));
        for (int k = 0; k < 4 && b0 + k < st_cyc0.size(); k++) begin
            check($sformatf("sq_side%0d", k), 256'(st_side0[b0 + k]), 256'(k));
            check($sformatf("sq_start_cyc%0d", k), 256'(st_cyc0[b0 + k]), 256'(hs + 3 * k));
        end
        check("sq_out_latency", 256'(out_rise[0]), 256'(hs + 12));
        check("sq_out_poly", 256'(out_poly_s[0]), 256'(exp_passes(pa, 4)));
        check("sq_culled", 256'(out_culled_s[0]), 256'(0));
        check("sq_err", 256'(out_err_s[0]), 256'(0));
        release_out();

        // Empty result on BOTTOM: early exit vs. full run
        cull_side = 1;
        b0 = st_cyc0.size(); b1 = st_cnt1;
        send(make_poly(5, 60));
        wait_out(0, 100, "cull_timeout");
        wait_out(1, 100, "cull_ns_timeout");
        check("cull_starts", 256'(st_cyc0.size() - b0), 256'(2));
        check("cull_culled", 256'(out_culled_s[0]), 256'(1));
        check("cull_err", 256'(out_err_s[0]), 256'(0));
        check("cull_nverts", 256'(out_poly_s[0].num_verts), 256'(0));
        check("cull_ns_starts", 256'(st_cnt1 - b1), 256'(4));
        check("cull_ns_culled", 256'(out_culled_s[1]), 256'(1));
        release_out();

        // Empty result on the final RIGHT pass
        cull_side = 3;
        b0 = st_cyc0.size();
        send(make_poly(6, 70));
        wait_out(0, 100, "rcull_timeout");
        check("rcull_starts", 256'(st_cyc0.size() - b0), 256'(4));
        check("rcull_culled", 256'(out_culled_s[0]), 256'(1));
        release_out();

        // Engine never answers
        cull_side = -1; eng_lat = 1000;
        pb = make_poly(4, 80);
        send(pb);
        wait_out(0, 100, "to_timeout");
        check("to_latency", 256'(out_rise[0]), 256'(hs + 65));
        check("to_err", 256'(out_err_s[0]), 256'(1));
        check("to_culled", 256'(out_culled_s[0]), 256'(0));
        pb.num_verts = '0;
        check("to_out_poly", 256'(out_poly_s[0]), 256'(pb));
        release_out();
        eng_lat = 2;
        pb = make_poly(4, 90);
        send(pb);
        wait_out(0, 100, "after_to_timeout");
        check("after_to_poly", 256'(out_poly_s[0]), 256'(exp_passes(pb, 4)));
        check("after_to_err", 256'(out_err_s[0]), 256'(0));
        release_out();

        // Done lands on the same cycle the timeout would fire
        eng_lat = 64;
        pb = make_poly(3, 20);
        send(pb);
        wait_out(0, 400, "coinc_timeout");
        check("coinc_latency", 256'(out_rise[0]), 256'(hs + 260));
        check("coinc_err", 256'(out_err_s[0]), 256'(0));
        check("coinc_poly", 256'(out_poly_s[0]), 256'(exp_passes(pb, 4)));
        release_out();

        // Backpressure with a waiting next polygon
        eng_lat = 2;
        pa = make_poly(4, 11);
        pb = make_poly(5, 22);
        send(pa);
        wait_out(0, 100, "bp_timeout");
        in_poly = pb; in_valid = 1'b1;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (out_poly_s[0] !== exp_passes(pa, 4) || in_ready_s[0] !== 1'b0 || out_valid_s[0] !== 1'b1)
                stable = 1'b0;
        end
        check("bp_hold", 256'(stable), 256'(1));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp_rel_in_ready", 256'(in_ready_s[0]), 256'(1));
        check("bp_rel_out_valid", 256'(out_valid_s[0]), 256'(0));
        @(posedge clk);
        #1 hs = cyc;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_accepted", 256'(busy_s[0]), 256'(1));
        wait_out(0, 100, "b2b_timeout");
        check("b2b_latency", 256'(out_rise[0]), 256'(hs + 12));
        check("b2b_poly", 256'(out_poly_s[0]), 256'(exp_passes(pb, 4)));
        release_out();

        // Spurious done in IDLE
        @(posedge clk);
        #1 spur_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 spur_done = 1'b0;
        @(negedge clk);
        check("spur_idle_busy", 256'(busy_s[0]), 256'(0));
        check("spur_idle_work", 256'(out_poly_s[0]), 256'(exp_passes(pb, 4)));

        // Spurious done in LAUNCH
        pc = make_poly(6, 33);
        send(pc);
        spur_done = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b0;
        wait_out(0, 100, "spur_launch_timeout");
        check("spur_launch_latency", 256'(out_rise[0]), 256'(hs + 12));
        check("spur_launch_poly", 256'(out_poly_s[0]), 256'(exp_passes(pc, 4)));

        // Spurious done in OUTPUT
        @(posedge clk);
        #1 spur_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 spur_done = 1'b0;
        @(negedge clk);
        check("spur_out_valid", 256'(out_valid_s[0]), 256'(1));
        check("spur_out_poly", 256'(out_poly_s[0]), 256'(exp_passes(pc, 4)));
        check("spur_out_err", 256'(out_err_s[0]), 256'(0));
        release_out();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
